// File: rtl/waveform_meter.sv
// waveform_meter: period / min / max meter for a unipolar sample stream.
// A period is delimited by two rising crossings of a threshold with
// hysteresis: the stream must fall to lo before a rise at hi is accepted.
// One result per measured period is offered on a valid/ready port; a sticky
// timeout flags a counter that saturates before a period completes.
module waveform_meter #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned HYST   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] threshold,
  output logic [CNT_W-1:0]  result_period,
  output logic [DATA_W-1:0] result_min,
  output logic [DATA_W-1:0] result_max,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              timeout
);

  // State encoding; StHold is the post-timeout wait for enable to drop.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StArm     = 3'd1;
  localparam logic [2:0] StFirst   = 3'd2;
  localparam logic [2:0] StMeasure = 3'd3;
  localparam logic [2:0] StReport  = 3'd4;
  localparam logic [2:0] StHold    = 3'd5;

  localparam logic [DATA_W:0]  HystX  = (DATA_W+1)'(HYST);
  localparam logic [DATA_W:0]  MaxX   = {1'b0, {DATA_W{1'b1}}};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic              rearm_q, rearm_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  res_period_q, res_period_d;
  logic [DATA_W-1:0] res_min_q, res_min_d;
  logic [DATA_W-1:0] res_max_q, res_max_d;
  logic              res_valid_q, res_valid_d;

  logic [DATA_W:0]   thr_x;
  logic [DATA_W:0]   hi_sum;
  logic [DATA_W:0]   lo_diff;
  logic [DATA_W-1:0] lo_calc;
  logic [DATA_W-1:0] hi_calc;
  logic              armed_ev;
  logic              rise_ev;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_sat;
  logic [DATA_W-1:0] min_upd;
  logic [DATA_W-1:0] max_upd;

  // Saturating hysteresis levels, computed one bit wider than the samples.
  always_comb begin
    thr_x   = {1'b0, threshold};
    hi_sum  = thr_x + HystX;
    lo_diff = thr_x - HystX;
    hi_calc = (hi_sum > MaxX) ? {DATA_W{1'b1}} : hi_sum[DATA_W-1:0];
    lo_calc = (thr_x < HystX) ? '0 : lo_diff[DATA_W-1:0];
  end

  // Per-sample events, counter step and running min/max candidates.
  always_comb begin
    armed_ev = sample_valid && (sample_in <= lo_q);
    rise_ev  = sample_valid && (sample_in >= hi_q);
    cnt_inc  = cnt_q + CNT_W'(1);
    // This sample would drive the counter to all-ones.
    cnt_sat  = sample_valid && (cnt_inc == CntMax);
    min_upd  = (sample_in < min_q) ? sample_in : min_q;
    max_upd  = (sample_in > max_q) ? sample_in : max_q;
  end

  // Next-state logic for the FSM, counter, extrema and result registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    max_d        = max_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    rearm_d      = rearm_q;
    timeout_d    = timeout_q;
    res_period_d = res_period_q;
    res_min_d    = res_min_q;
    res_max_d    = res_max_q;
    res_valid_d  = res_valid_q;

    if (!enable) begin
      // Result data and timeout are kept; only the handshake is withdrawn.
      state_d     = StIdle;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d   = StArm;
          cnt_d     = '0;
          timeout_d = 1'b0;
          rearm_d   = 1'b0;
          lo_d      = lo_calc;
          hi_d      = hi_calc;
        end

        StArm: begin
          if (armed_ev) begin
            state_d = StFirst;
            cnt_d   = '0;
          end else if (sample_valid) begin
            cnt_d = cnt_inc;
            if (cnt_sat) begin
              timeout_d = 1'b1;
              state_d   = StHold;
            end
          end
        end

        StFirst: begin
          if (rise_ev) begin
            // The opening rise sample is not part of the measured period.
            state_d = StMeasure;
            cnt_d   = '0;
            min_d   = {DATA_W{1'b1}};
            max_d   = '0;
            rearm_d = 1'b0;
          end else if (sample_valid) begin
            cnt_d = cnt_inc;
            if (cnt_sat) begin
              timeout_d = 1'b1;
              state_d   = StHold;
            end
          end
        end

        StMeasure: begin
          if (sample_valid) begin
            cnt_d = cnt_inc;
            min_d = min_upd;
            max_d = max_upd;
            if (armed_ev) begin
              rearm_d = 1'b1;
            end
            // A closing rise wins over a simultaneous counter saturation.
            if (rise_ev && rearm_q) begin
              state_d      = StReport;
              res_period_d = cnt_inc;
              res_min_d    = min_upd;
              res_max_d    = max_upd;
              res_valid_d  = 1'b1;
            end else if (cnt_sat) begin
              timeout_d = 1'b1;
              state_d   = StHold;
            end
          end
        end

        StReport: begin
          if (res_valid_q && result_ready) begin
            state_d     = StArm;
            res_valid_d = 1'b0;
            rearm_d     = 1'b0;
            cnt_d       = '0;
          end
        end

        StHold: begin
          state_d = StHold;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      rearm_q      <= 1'b0;
      timeout_q    <= 1'b0;
      res_period_q <= '0;
      res_min_q    <= '0;
      res_max_q    <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      rearm_q      <= rearm_d;
      timeout_q    <= timeout_d;
      res_period_q <= res_period_d;
      res_min_q    <= res_min_d;
      res_max_q    <= res_max_d;
      res_valid_q  <= res_valid_d;
    end
  end

  assign result_period = res_period_q;
  assign result_min    = res_min_q;
  assign result_max    = res_max_q;
  assign result_valid  = res_valid_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_waveform_meter.sv
// Directed bench for waveform_meter (CNT_W reduced to 8 so saturation is reachable).
module tb_waveform_meter;

  localparam int unsigned DATA_W = 14;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned HYST   = 64;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [DATA_W-1:0] threshold;
  logic [CNT_W-1:0]  result_period;
  logic [DATA_W-1:0] result_min;
  logic [DATA_W-1:0] result_max;
  logic              result_valid;
  logic              result_ready;
  logic              timeout;

  int n_vec;
  int n_err;

  waveform_meter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .HYST   (HYST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .threshold     (threshold),
    .result_period (result_period),
    .result_min    (result_min),
    .result_max    (result_max),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one input cycle; returns 1 time unit after the active edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d);
    sample_valid = v;
    sample_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [DATA_W-1:0] d);
    for (int i = 0; i < n; i++) step(1'b1, d);
  endtask

  // Pass through IDLE with a new threshold and return in ARM.
  task automatic restart(input logic [DATA_W-1:0] thr);
    enable = 1'b0;
    step(1'b0, '0);
    threshold = thr;
    enable    = 1'b1;
    step(1'b0, '0);
  endtask

  task automatic check_result(input string tag, input int per, input int mn, input int mx);
    check({tag, "_valid"}, 64'(result_valid), 64'(1));
    check({tag, "_period"}, 64'(result_period), 64'(per));
    check({tag, "_min"}, 64'(result_min), 64'(mn));
    check({tag, "_max"}, 64'(result_max), 64'(mx));
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    threshold    = 14'd8192;
    result_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    #1;
    check("rst_outputs", 64'({result_valid, timeout, result_period, result_min, result_max}),
          64'(0));

    // Square wave 0/16383, 50+50, threshold 8192.
    restart(14'd8192);
    feed(50, 14'd0);
    feed(50, 14'd16383);
    feed(50, 14'd0);
    check("sq_no_early", 64'(result_valid), 64'(0));
    step(1'b1, 14'd16383);
    check_result("sq1", 100, 0, 16383);
    step(1'b1, 14'd16383);
    check("sq1_handshake", 64'(result_valid), 64'(0));
    check("sq1_retained", 64'(result_period), 64'(100));
    feed(48, 14'd16383);
    feed(50, 14'd0);
    feed(50, 14'd16383);
    feed(50, 14'd0);
    step(1'b1, 14'd16383);
    check_result("sq2", 100, 0, 16383);
    step(1'b1, 14'd16383);

    // Sawtooth with a bubble every other cycle; bubbles carry a bogus full-scale value.
    restart(14'd8192);
    for (int k = 0; k < 128; k++) begin
      step(1'b1, 14'(k * 128));
      step(1'b0, 14'd16383);
    end
    for (int k = 0; k < 65; k++) begin
      step(1'b1, 14'(k * 128));
      step(1'b0, 14'd16383);
    end
    check("saw_no_early", 64'(result_valid), 64'(0));
    step(1'b1, 14'(65 * 128));
    check_result("saw", 128, 0, 16256);
    step(1'b0, 14'd16383);
    check("saw_handshake", 64'(result_valid), 64'(0));

    // Result held 40 cycles with ready low while the input keeps moving.
    restart(14'd8192);
    result_ready = 1'b0;
    feed(50, 14'd0);
    feed(50, 14'd16383);
    feed(50, 14'd0);
    step(1'b1, 14'd16383);
    check_result("hold", 100, 0, 16383);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i % 2 == 0) ? 14'd0 : 14'd16383);
      check("hold_stable", 64'({result_valid, result_period, result_min, result_max}),
            64'({1'b1, 8'd100, 14'd0, 14'd16383}));
    end
    result_ready = 1'b1;
    step(1'b1, 14'd16383);
    check("hold_release", 64'(result_valid), 64'(0));
    feed(8, 14'd16383);
    feed(50, 14'd0);
    feed(50, 14'd16383);
    feed(50, 14'd0);
    check("hold_no_early", 64'(result_valid), 64'(0));
    step(1'b1, 14'd16383);
    check_result("hold_next", 100, 0, 16383);
    step(1'b0, 14'd0);

    // Low threshold: lo saturates to 0, hi = 94.
    restart(14'd30);
    feed(10, 14'd0);
    feed(10, 14'd200);
    feed(10, 14'd0);
    step(1'b1, 14'd200);
    check_result("lowthr", 20, 0, 200);
    step(1'b0, 14'd0);

    // Closing rise coincides with counter saturation: period completes.
    restart(14'd8192);
    feed(127, 14'd0);
    feed(128, 14'd16383);
    feed(127, 14'd0);
    step(1'b1, 14'd16383);
    check_result("sat_close", 255, 0, 16383);
    check("sat_close_to", 64'(timeout), 64'(0));
    step(1'b0, 14'd0);

    // One sample longer: saturation inside MEASURE times out.
    restart(14'd8192);
    feed(128, 14'd0);
    feed(128, 14'd16383);
    feed(127, 14'd0);
    check("meas_pre_to", 64'(timeout), 64'(0));
    step(1'b1, 14'd0);
    check("meas_to", 64'(timeout), 64'(1));
    step(1'b1, 14'd16383);
    check("meas_to_noresult", 64'(result_valid), 64'(0));

    // Samples dithering inside the hysteresis band never arm.
    restart(14'd8192);
    for (int i = 0; i < 254; i++) step(1'b1, (i % 2 == 0) ? 14'd8180 : 14'd8200);
    check("dither_pre_to", 64'(timeout), 64'(0));
    step(1'b1, 14'd8180);
    check("dither_to", 64'(timeout), 64'(1));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 14'd0);
      step(1'b1, 14'd16383);
    end
    check("dither_wait", 64'({result_valid, timeout}), 64'({1'b0, 1'b1}));
    restart(14'd8192);
    check("dither_cleared", 64'(timeout), 64'(0));

    // Asynchronous reset between edges mid-MEASURE.
    feed(50, 14'd0);
    feed(10, 14'd16383);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 64'({result_valid, timeout, result_period, result_min, result_max}),
          64'(0));
    #1;
    rst_n = 1'b1;
    step(1'b1, 14'd16383);
    feed(40, 14'd16383);
    feed(50, 14'd0);
    feed(50, 14'd16383);
    feed(50, 14'd0);
    check("rst_no_early", 64'(result_valid), 64'(0));
    step(1'b1, 14'd16383);
    check_result("after_rst", 100, 0, 16383);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
